// File: rtl/wptr_full_ctrl.sv
// Write-side pointer and full/almost-full/overflow flag controller.
// Optional registered fill level on wlevel when WPTR_FULL_WLEVEL_EN is defined.
module wptr_full_ctrl #(
   parameter int ADDRSIZE   = 4,
   parameter int AWFULLSIZE = 1
) (
   input  logic                wclk,
   input  logic                wrst,
   input  logic                winc,
   input  logic [ADDRSIZE:0]   wq2_rptr,
   output logic                wfull,
   output logic                awfull,
   output logic                woverflow,
   output logic [ADDRSIZE-1:0] waddr,
   output logic [ADDRSIZE:0]   wptr
`ifdef WPTR_FULL_WLEVEL_EN
   ,
   output logic [ADDRSIZE:0]   wlevel
`endif
);

   localparam int DEPTH = 1 << ADDRSIZE;
   localparam logic [ADDRSIZE:0] AF_TH =
      (ADDRSIZE+1)'(DEPTH - AWFULLSIZE);

   logic [ADDRSIZE:0] r_wbin;
   logic [ADDRSIZE:0] r_wptr;
   logic              r_wfull;
   logic              r_awfull;
   logic              r_wovf;

   logic              w_we;
   logic [ADDRSIZE:0] w_wbin_next;
   logic [ADDRSIZE:0] w_wgray_next;
   logic [ADDRSIZE:0] w_rbin;
   logic [ADDRSIZE:0] w_level_next;
   logic [ADDRSIZE:0] w_full_cmp;
   logic              w_full_next;
   logic              w_afull_next;

   assign w_we         = winc & ~r_wfull;
   assign w_wbin_next  = r_wbin + {{ADDRSIZE{1'b0}}, w_we};
   assign w_wgray_next = (w_wbin_next >> 1) ^ w_wbin_next;

   // Gray-to-binary of the synchronized read pointer: bit i is XOR of bits i..MSB
   always_comb begin
      w_rbin = '0;
      for (int i = 0; i <= ADDRSIZE; i++) begin
         w_rbin[i] = ^(wq2_rptr >> i);
      end
   end

   assign w_level_next = w_wbin_next - w_rbin;

   // Full when next Gray write pointer equals read pointer with top two bits inverted
   assign w_full_cmp   = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1],
                          wq2_rptr[ADDRSIZE-2:0]};
   assign w_full_next  = (w_wgray_next == w_full_cmp);
   assign w_afull_next = (w_level_next >= AF_TH) | w_full_next;

   // Pointer and flag registers; overflow is sticky until reset
   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         r_wbin   <= '0;
         r_wptr   <= '0;
         r_wfull  <= 1'b0;
         r_awfull <= 1'b0;
         r_wovf   <= 1'b0;
      end else begin
         r_wbin   <= w_wbin_next;
         r_wptr   <= w_wgray_next;
         r_wfull  <= w_full_next;
         r_awfull <= w_afull_next;
         r_wovf   <= r_wovf | (winc & r_wfull);
      end
   end

`ifdef WPTR_FULL_WLEVEL_EN
   logic [ADDRSIZE:0] r_wlevel;

   // Registered fill level seen from the write side
   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         r_wlevel <= '0;
      end else begin
         r_wlevel <= w_level_next;
      end
   end

   assign wlevel = r_wlevel;
`endif

   assign waddr     = r_wbin[ADDRSIZE-1:0];
   assign wptr      = r_wptr;
   assign wfull     = r_wfull;
   assign awfull    = r_awfull;
   assign woverflow = r_wovf;

endmodule
